// File: rtl/axi_pkg.sv
// Shared AXI3 read-channel types for the boot ROM slave.
package axi_pkg;

    localparam int unsigned AxiIdWidth = 4;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [31:0]           addr;
        logic [3:0]            len;
        logic [2:0]            size;
        axi_burst_t            burst;
    } axi_ar_t;

    // Only power-of-two beat counts wrap; anything else behaves as INCR.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding R beats (data, resp, last) between the ROM and the R channel.
module rd_skid_fifo #(
    parameter int unsigned WIDTH = 35
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/axi3_bootrom_slave.sv
// AXI3 read-only slave in front of a 1-cycle-latency synchronous boot ROM.
module axi3_bootrom_slave
    import axi_pkg::*;
#(
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter int unsigned ID_WIDTH       = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [31:0]               araddr,
    input  logic [3:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [31:0]               rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      rom_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]               rom_rdata
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e      state_q, state_d;
    axi_ar_t     ar_q, ar_d;
    logic        err_q, err_d;
    logic [4:0]  issue_cnt_q, issue_cnt_d;
    logic        live_q;
    logic        inflight_q;
    logic        last_inflight_q;

    logic        issue;
    logic        pop;
    logic [31:0] step, wrap_mask, next_addr;
    logic [2:0]  occupancy, credit;
    logic [34:0] fifo_wdata, fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic [1:0]  fifo_count;
    axi_resp_t   beat_resp;

    // live_q holds arready low on the cycle a synchronous reset is still in effect.
    assign arready = (state_q == StIdle) && live_q;
    assign rvalid  = !fifo_empty;
    assign pop     = rvalid && rready;
    assign {rdata, rresp, rlast} = fifo_rdata;
    assign rid      = ID_WIDTH'(ar_q.id);
    assign rom_addr = ar_q.addr[ROM_ADDR_WIDTH+1:2];
    assign rom_en   = issue && !err_q;

    // A beat leaving this cycle frees a slot by the time a new read lands.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit    = 3'd2 + {2'b00, pop};
    assign issue     = (state_q == StBurst) && (issue_cnt_q <= {1'b0, ar_q.len})
                       && (occupancy < credit) && (!fifo_full || pop);

    always_comb begin
        step      = 32'd1 << ar_q.size;
        wrap_mask = ((32'(ar_q.len) + 32'd1) << ar_q.size) - 32'd1;
        next_addr = ar_q.addr + step;
        if (ar_q.burst == BurstFixed) begin
            next_addr = ar_q.addr;
        end else if (ar_q.burst == BurstWrap && wrap_len_ok(ar_q.len)) begin
            next_addr = (ar_q.addr & ~wrap_mask) | ((ar_q.addr + step) & wrap_mask);
        end
    end

    always_comb begin
        beat_resp  = err_q ? RespSlverr : RespOkay;
        fifo_wdata = {(err_q ? 32'd0 : rom_rdata), 2'(beat_resp), last_inflight_q};
    end

    always_comb begin
        state_d     = state_q;
        ar_d        = ar_q;
        err_d       = err_q;
        issue_cnt_d = issue_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arvalid && arready) begin
                    state_d     = StBurst;
                    ar_d.id     = AxiIdWidth'(arid);
                    ar_d.addr   = araddr;
                    ar_d.len    = arlen;
                    ar_d.size   = arsize;
                    ar_d.burst  = axi_burst_t'(arburst);
                    err_d       = (arburst == 2'b11) || (arsize > 3'd2);
                    issue_cnt_d = 5'd0;
                end
            end
            StBurst: begin
                if (issue) begin
                    ar_d.addr   = next_addr;
                    issue_cnt_d = issue_cnt_q + 5'd1;
                end
                if (pop && rlast) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= StIdle;
            ar_q            <= '0;
            err_q           <= 1'b0;
            issue_cnt_q     <= 5'd0;
            live_q          <= 1'b0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ar_q            <= ar_d;
            err_q           <= err_d;
            issue_cnt_q     <= issue_cnt_d;
            live_q          <= 1'b1;
            inflight_q      <= issue;
            last_inflight_q <= issue && (issue_cnt_q == {1'b0, ar_q.len});
        end
    end

    rd_skid_fifo #(
        .WIDTH(35)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (inflight_q),
        .push_data (fifo_wdata),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
